// File: rtl/hazard_mc_if.sv
// ----------------------------------------------------------------------------
// hazard_mc_if
// Bundles every non-clock/reset signal of the hazard unit.
//   master : pipeline side, drives stage indices/controls, reads hazard results
//   slave  : hazard unit, reads stage indices/controls, drives stalls/flushes,
//            forwarding selects, MC busy flag and performance counters
// Parameters: RA_W register-index width, CNT_W performance-counter width.
// ----------------------------------------------------------------------------
interface hazard_mc_if #(
    parameter int RA_W  = 4,
    parameter int CNT_W = 16
);
    // D/E/M/W stage register indices
    logic [RA_W-1:0]  RA1D, RA2D;
    logic [RA_W-1:0]  RA1E, RA2E, WA3E;
    logic [RA_W-1:0]  WA3M, RA2M;
    logic [RA_W-1:0]  WA3W;
    // stage controls
    logic             MemtoRegE, RegWriteE, PCSrcE;
    logic             MCStartE, MCDone;
    logic             RegWriteM, MemWriteM;
    logic             RegWriteW, MemtoRegW;
    logic             CntClear;
    // hazard results
    logic             StallF, StallD, StallE;
    logic             FlushD, FlushE, FlushM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             ForwardM;
    logic             MCBusy;
    logic [CNT_W-1:0] LdrStallCnt, McStallCnt, FlushCnt;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, RA2M, WA3W,
               MemtoRegE, RegWriteE, PCSrcE, MCStartE, MCDone,
               RegWriteM, MemWriteM, RegWriteW, MemtoRegW, CntClear,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
               ForwardAE, ForwardBE, ForwardM, MCBusy,
               LdrStallCnt, McStallCnt, FlushCnt
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, RA2M, WA3W,
               MemtoRegE, RegWriteE, PCSrcE, MCStartE, MCDone,
               RegWriteM, MemWriteM, RegWriteW, MemtoRegW, CntClear,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
               ForwardAE, ForwardBE, ForwardM, MCBusy,
               LdrStallCnt, McStallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_mc.sv
// ----------------------------------------------------------------------------
// hazard_mc
// Hazard unit for the 5-stage ARM pipeline: E-stage operand forwarding,
// LDR->STR memory forwarding, load-use stall, branch flush, and a stall FSM
// that freezes F/D/E while a multi-cycle op (MUL/DIV) occupies E.
// Saturating performance counters track load-use stalls, MC stalls, flushes.
//
// Ports:
//   CLK     in  rising-edge clock
//   RESETn  in  asynchronous active-low reset
//   bus     hazard_mc_if.slave: stage indices/controls in; Stall*/Flush*,
//           Forward*, MCBusy and the three counters out
// Parameters:
//   RA_W         register-index width
//   MC_LATENCY   E-stage occupancy of an MC op in fixed mode (>=1)
//   MC_EXT_DONE  0: fixed-latency down-counter, 1: completion on MCDone
//   CNT_W        performance-counter width
// ----------------------------------------------------------------------------
module hazard_mc #(
    parameter int RA_W        = 4,
    parameter int MC_LATENCY  = 4,
    parameter int MC_EXT_DONE = 0,
    parameter int CNT_W       = 16
) (
    input  logic       CLK,
    input  logic       RESETn,
    hazard_mc_if.slave bus
);

    localparam int MC_CNT_W = $clog2(MC_LATENCY) + 1;
    localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'(MC_LATENCY - 1);
    // A single-cycle op in fixed mode never needs to hold the pipeline.
    localparam bit MC_START_OK = (MC_EXT_DONE != 0) || (MC_LATENCY >= 2);

    typedef logic [RA_W-1:0] ra_t;
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    // M-stage result has priority over the older W-stage result.
    function automatic logic [1:0] fwd_sel(input ra_t src, input ra_t wa_m,
                                           input logic rw_m, input ra_t wa_w,
                                           input logic rw_w);
        if (rw_m && (src == wa_m))      return 2'b10;
        else if (rw_w && (src == wa_w)) return 2'b01;
        else                            return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
        return v;
    endfunction

    state_t              r_state, w_state_nxt;
    logic [MC_CNT_W-1:0] r_mc_cnt, w_mc_cnt_nxt;
    logic                w_finish;
    logic                w_mc_stall;
    logic                w_ldr_stall;
    logic                w_flush_d;
    logic [CNT_W-1:0]    r_ldr_cnt, r_mc_stall_cnt, r_flush_cnt;

    assign w_ldr_stall = ((bus.RA1D == bus.WA3E) || (bus.RA2D == bus.WA3E)) &&
                         bus.MemtoRegE && bus.RegWriteE;

    always_comb begin
        w_finish = 1'b0;
        if (MC_EXT_DONE != 0) w_finish = bus.MCDone;
        else                  w_finish = (r_mc_cnt == MC_CNT_W'(1));
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state  <= ST_IDLE;
            r_mc_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc_cnt <= w_mc_cnt_nxt;
        end
    end

    // The stall is asserted in the cycle the op is first seen, before the
    // FSM has registered BUSY, so the op cannot slip out of E.
    always_comb begin
        w_state_nxt  = r_state;
        w_mc_cnt_nxt = r_mc_cnt;
        w_mc_stall   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.MCStartE && MC_START_OK) begin
                    w_state_nxt  = ST_BUSY;
                    w_mc_cnt_nxt = MC_LOAD;
                    w_mc_stall   = 1'b1;
                end
            end
            ST_BUSY: begin
                if (MC_EXT_DONE == 0) w_mc_cnt_nxt = r_mc_cnt - MC_CNT_W'(1);
                if (w_finish) w_state_nxt = ST_IDLE;
                else          w_mc_stall  = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // MC stall wins: the op must stay in E, so neither a load-use bubble nor
    // a branch flush may disturb D/E while it is frozen.
    assign w_flush_d     = bus.PCSrcE && !w_mc_stall;
    assign bus.StallF    = w_ldr_stall || w_mc_stall;
    assign bus.StallD    = w_ldr_stall || w_mc_stall;
    assign bus.StallE    = w_mc_stall;
    assign bus.FlushM    = w_mc_stall;
    assign bus.FlushE    = (w_ldr_stall || bus.PCSrcE) && !w_mc_stall;
    assign bus.FlushD    = w_flush_d;
    assign bus.MCBusy    = (r_state == ST_BUSY);

    assign bus.ForwardAE = fwd_sel(bus.RA1E, bus.WA3M, bus.RegWriteM,
                                   bus.WA3W, bus.RegWriteW);
    assign bus.ForwardBE = fwd_sel(bus.RA2E, bus.WA3M, bus.RegWriteM,
                                   bus.WA3W, bus.RegWriteW);
    assign bus.ForwardM  = (bus.RA2M == bus.WA3W) && bus.MemWriteM &&
                           bus.MemtoRegW && bus.RegWriteW;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_ldr_cnt      <= '0;
            r_mc_stall_cnt <= '0;
            r_flush_cnt    <= '0;
        end else if (bus.CntClear) begin
            r_ldr_cnt      <= '0;
            r_mc_stall_cnt <= '0;
            r_flush_cnt    <= '0;
        end else begin
            r_ldr_cnt      <= sat_inc(r_ldr_cnt, w_ldr_stall && !w_mc_stall);
            r_mc_stall_cnt <= sat_inc(r_mc_stall_cnt, w_mc_stall);
            r_flush_cnt    <= sat_inc(r_flush_cnt, w_flush_d);
        end
    end

    assign bus.LdrStallCnt = r_ldr_cnt;
    assign bus.McStallCnt  = r_mc_stall_cnt;
    assign bus.FlushCnt    = r_flush_cnt;

endmodule

// File: tb/tb_hazard_mc.sv
// ----------------------------------------------------------------------------
// tb_hazard_mc
// Three hazard units share one stimulus stream:
//   A: fixed latency 4, 16-bit counters
//   B: external completion (MCDone), 16-bit counters
//   C: fixed latency 1 (never stalls on MC ops), 2-bit counters
// The reference model tracks an MC op by its elapsed cycles in E and keeps
// counters as plain integers clipped at their maximum.
// ----------------------------------------------------------------------------
module tb_hazard_mc;

    logic CLK = 1'b0;
    logic RESETn;
    always #5 CLK = ~CLK;

    hazard_mc_if #(.RA_W(4), .CNT_W(16)) if_a ();
    hazard_mc_if #(.RA_W(4), .CNT_W(16)) if_b ();
    hazard_mc_if #(.RA_W(4), .CNT_W(2))  if_c ();

    hazard_mc #(.RA_W(4), .MC_LATENCY(4), .MC_EXT_DONE(0), .CNT_W(16)) dut_a (
        .CLK(CLK), .RESETn(RESETn), .bus(if_a.slave));
    hazard_mc #(.RA_W(4), .MC_LATENCY(4), .MC_EXT_DONE(1), .CNT_W(16)) dut_b (
        .CLK(CLK), .RESETn(RESETn), .bus(if_b.slave));
    hazard_mc #(.RA_W(4), .MC_LATENCY(1), .MC_EXT_DONE(0), .CNT_W(2)) dut_c (
        .CLK(CLK), .RESETn(RESETn), .bus(if_c.slave));

    typedef struct packed {
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, ra2m, wa3w;
        logic memtorege, regwritee, pcsrce, mcstarte, mcdone;
        logic regwritem, memwritem, regwritew, memtoregw, cntclear;
    } in_t;

    in_t cur;
    int  checks = 0;
    int  errors = 0;

    // model state: m_age = cycles the current MC op has spent in E (0 = none)
    int  m_age [3];
    bit  m_ext_busy;
    int  m_ldr [3];
    int  m_mc  [3];
    int  m_fl  [3];

    function automatic int lat(int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic int cmax(int k);
        return (k == 2) ? 3 : 65535;
    endfunction

    function automatic logic [1:0] exp_fwd(logic [3:0] src);
        if (cur.regwritem && src == cur.wa3m) return 2'b10;
        if (cur.regwritew && src == cur.wa3w) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic exp_busy(int k);
        if (k == 1) return m_ext_busy;
        return m_age[k] > 0;
    endfunction

    function automatic logic exp_mc(int k);
        if (k == 1) return m_ext_busy ? !cur.mcdone : cur.mcstarte;
        if (m_age[k] > 0) return m_age[k] < lat(k) - 1;
        return cur.mcstarte && (lat(k) >= 2);
    endfunction

    function automatic logic exp_ldr();
        return ((cur.ra1d == cur.wa3e) || (cur.ra2d == cur.wa3e)) &&
               cur.memtorege && cur.regwritee;
    endfunction

    // {StallF,StallD,StallE,FlushD,FlushE,FlushM,FwdAE,FwdBE,FwdM,MCBusy}
    function automatic logic [11:0] exp_vec(int k);
        logic mc, ld, fm;
        mc = exp_mc(k);
        ld = exp_ldr();
        fm = (cur.ra2m == cur.wa3w) && cur.memwritem && cur.memtoregw && cur.regwritew;
        return {ld | mc, ld | mc, mc, cur.pcsrce & ~mc, (ld | cur.pcsrce) & ~mc, mc,
                exp_fwd(cur.ra1e), exp_fwd(cur.ra2e), fm, exp_busy(k)};
    endfunction

    function automatic logic [11:0] obs_vec(int k);
        case (k)
            0: return {if_a.StallF, if_a.StallD, if_a.StallE, if_a.FlushD, if_a.FlushE,
                       if_a.FlushM, if_a.ForwardAE, if_a.ForwardBE, if_a.ForwardM, if_a.MCBusy};
            1: return {if_b.StallF, if_b.StallD, if_b.StallE, if_b.FlushD, if_b.FlushE,
                       if_b.FlushM, if_b.ForwardAE, if_b.ForwardBE, if_b.ForwardM, if_b.MCBusy};
            default: return {if_c.StallF, if_c.StallD, if_c.StallE, if_c.FlushD, if_c.FlushE,
                       if_c.FlushM, if_c.ForwardAE, if_c.ForwardBE, if_c.ForwardM, if_c.MCBusy};
        endcase
    endfunction

    // which: 0 = LdrStallCnt, 1 = McStallCnt, 2 = FlushCnt
    function automatic int obs_cnt(int k, int which);
        case (k)
            0: return (which == 0) ? int'(if_a.LdrStallCnt) :
                      (which == 1) ? int'(if_a.McStallCnt) : int'(if_a.FlushCnt);
            1: return (which == 0) ? int'(if_b.LdrStallCnt) :
                      (which == 1) ? int'(if_b.McStallCnt) : int'(if_b.FlushCnt);
            default: return (which == 0) ? int'(if_c.LdrStallCnt) :
                      (which == 1) ? int'(if_c.McStallCnt) : int'(if_c.FlushCnt);
        endcase
    endfunction

    function automatic int exp_cnt(int k, int which);
        return (which == 0) ? m_ldr[k] : (which == 1) ? m_mc[k] : m_fl[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_age[k] = 0; m_ldr[k] = 0; m_mc[k] = 0; m_fl[k] = 0;
        end
        m_ext_busy = 1'b0;
    endtask

    task automatic model_edge();
        logic mc, ld, fd;
        if (!RESETn) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            mc = exp_mc(k);
            ld = exp_ldr();
            fd = cur.pcsrce && !mc;
            if (cur.cntclear) begin
                m_ldr[k] = 0; m_mc[k] = 0; m_fl[k] = 0;
            end else begin
                if (ld && !mc && m_ldr[k] < cmax(k)) m_ldr[k]++;
                if (mc && m_mc[k] < cmax(k))         m_mc[k]++;
                if (fd && m_fl[k] < cmax(k))         m_fl[k]++;
            end
            if (k == 1) begin
                m_ext_busy = m_ext_busy ? !cur.mcdone : cur.mcstarte;
            end else if (m_age[k] > 0) begin
                m_age[k] = (m_age[k] >= lat(k) - 1) ? 0 : m_age[k] + 1;
            end else if (cur.mcstarte && lat(k) >= 2) begin
                m_age[k] = 1;
            end
        end
    endtask

    task automatic drive();
        if_a.RA1D = cur.ra1d; if_b.RA1D = cur.ra1d; if_c.RA1D = cur.ra1d;
        if_a.RA2D = cur.ra2d; if_b.RA2D = cur.ra2d; if_c.RA2D = cur.ra2d;
        if_a.RA1E = cur.ra1e; if_b.RA1E = cur.ra1e; if_c.RA1E = cur.ra1e;
        if_a.RA2E = cur.ra2e; if_b.RA2E = cur.ra2e; if_c.RA2E = cur.ra2e;
        if_a.WA3E = cur.wa3e; if_b.WA3E = cur.wa3e; if_c.WA3E = cur.wa3e;
        if_a.WA3M = cur.wa3m; if_b.WA3M = cur.wa3m; if_c.WA3M = cur.wa3m;
        if_a.RA2M = cur.ra2m; if_b.RA2M = cur.ra2m; if_c.RA2M = cur.ra2m;
        if_a.WA3W = cur.wa3w; if_b.WA3W = cur.wa3w; if_c.WA3W = cur.wa3w;
        if_a.MemtoRegE = cur.memtorege; if_b.MemtoRegE = cur.memtorege; if_c.MemtoRegE = cur.memtorege;
        if_a.RegWriteE = cur.regwritee; if_b.RegWriteE = cur.regwritee; if_c.RegWriteE = cur.regwritee;
        if_a.PCSrcE    = cur.pcsrce;    if_b.PCSrcE    = cur.pcsrce;    if_c.PCSrcE    = cur.pcsrce;
        if_a.MCStartE  = cur.mcstarte;  if_b.MCStartE  = cur.mcstarte;  if_c.MCStartE  = cur.mcstarte;
        if_a.MCDone    = cur.mcdone;    if_b.MCDone    = cur.mcdone;    if_c.MCDone    = cur.mcdone;
        if_a.RegWriteM = cur.regwritem; if_b.RegWriteM = cur.regwritem; if_c.RegWriteM = cur.regwritem;
        if_a.MemWriteM = cur.memwritem; if_b.MemWriteM = cur.memwritem; if_c.MemWriteM = cur.memwritem;
        if_a.RegWriteW = cur.regwritew; if_b.RegWriteW = cur.regwritew; if_c.RegWriteW = cur.regwritew;
        if_a.MemtoRegW = cur.memtoregw; if_b.MemtoRegW = cur.memtoregw; if_c.MemtoRegW = cur.memtoregw;
        if_a.CntClear  = cur.cntclear;  if_b.CntClear  = cur.cntclear;  if_c.CntClear  = cur.cntclear;
        #1;
    endtask

    // advance one clock; callers run between negedge and the next posedge
    task automatic tick();
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        cur = '0;
        model_reset();
        drive();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                errors++; $display("FAIL reset_outputs[%0d]: got %h expected %h", k, obs_vec(k), exp_vec(k));
            end
            for (int w = 0; w < 3; w++) begin
                checks++;
                if (obs_cnt(k, w) != 0) begin
                    errors++; $display("FAIL reset_counter[%0d][%0d]: got %0d expected 0", k, w, obs_cnt(k, w));
                end
            end
        end
        tick();
        RESETn = 1'b1;
        tick();
    endtask

    task automatic test_forwarding();
        cur = '0;
        cur.ra1e = 4'd3; cur.wa3m = 4'd3; cur.regwritem = 1'b1;
        cur.wa3w = 4'd3; cur.regwritew = 1'b1;
        drive();
        checks++;
        if (if_a.ForwardAE !== 2'b10) begin
            errors++; $display("FAIL fwd_m_priority: got %b expected 10", if_a.ForwardAE);
        end
        tick();
        cur.regwritem = 1'b0;
        drive();
        checks++;
        if (if_a.ForwardAE !== 2'b01) begin
            errors++; $display("FAIL fwd_from_w: got %b expected 01", if_a.ForwardAE);
        end
        tick();
        cur.ra2m = 4'd5; cur.wa3w = 4'd5; cur.memwritem = 1'b1; cur.memtoregw = 1'b1;
        drive();
        checks++;
        if (if_a.ForwardM !== 1'b1) begin
            errors++; $display("FAIL fwd_mem: got %b expected 1", if_a.ForwardM);
        end
        checks++;
        if (obs_vec(0) !== exp_vec(0)) begin
            errors++; $display("FAIL fwd_vector: got %h expected %h", obs_vec(0), exp_vec(0));
        end
        tick();
    endtask

    task automatic test_load_use();
        cur = '0;
        cur.ra2d = 4'd7; cur.wa3e = 4'd7; cur.memtorege = 1'b1; cur.regwritee = 1'b1;
        drive();
        checks++;
        if ({if_a.StallF, if_a.StallD, if_a.FlushE, if_a.StallE} !== 4'b1110) begin
            errors++; $display("FAIL load_use_ctrl: got %b expected 1110",
                {if_a.StallF, if_a.StallD, if_a.FlushE, if_a.StallE});
        end
        checks++;
        if (if_a.LdrStallCnt !== 16'd0) begin
            errors++; $display("FAIL load_use_cnt_before: got %0d expected 0", if_a.LdrStallCnt);
        end
        tick();
        checks++;
        if (if_a.LdrStallCnt !== 16'd1) begin
            errors++; $display("FAIL load_use_cnt_after: got %0d expected 1", if_a.LdrStallCnt);
        end
        cur = '0;
        drive();
        tick();
    endtask

    task automatic test_fixed_mul();
        int         sa = 0, sc = 0;
        logic [3:0] busy_pat = '0;
        cur = '0;
        cur.mcstarte = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    errors++; $display("FAIL mul_cycle%0d[%0d]: got %h expected %h", i, k, obs_vec(k), exp_vec(k));
                end
            end
            if (if_a.StallF && if_a.StallD && if_a.StallE && if_a.FlushM) sa++;
            busy_pat[i] = if_a.MCBusy;
            if (if_c.StallE || if_c.MCBusy) sc++;
            tick();
        end
        checks++;
        if (sa != 3) begin
            errors++; $display("FAIL mul_stall_cycles: got %0d expected 3", sa);
        end
        checks++;
        if (busy_pat !== 4'b1110) begin
            errors++; $display("FAIL mul_busy_pattern: got %b expected 1110", busy_pat);
        end
        checks++;
        if (if_a.McStallCnt !== 16'd3) begin
            errors++; $display("FAIL mul_stall_cnt: got %0d expected 3", if_a.McStallCnt);
        end
        checks++;
        if (sc != 0) begin
            errors++; $display("FAIL mul_latency1_nostall: got %0d expected 0", sc);
        end
        // MCDone pulse: ignored by the idle fixed unit, releases the ext unit
        cur.mcstarte = 1'b0; cur.mcdone = 1'b1;
        drive();
        checks++;
        if (obs_vec(1) !== exp_vec(1)) begin
            errors++; $display("FAIL ext_release: got %h expected %h", obs_vec(1), exp_vec(1));
        end
        tick();
        cur = '0;
        drive();
        checks++;
        if (if_a.MCBusy !== 1'b0 || if_b.MCBusy !== 1'b0) begin
            errors++; $display("FAIL done_in_idle: got %b%b expected 00", if_a.MCBusy, if_b.MCBusy);
        end
        tick();
    endtask

    task automatic test_ext_mode();
        int   sb = 0;
        logic fd_b = 1'b0;
        cur = '0;
        for (int i = 1; i <= 6; i++) begin
            cur.mcstarte = 1'b1;
            cur.pcsrce   = (i <= 5);
            cur.mcdone   = (i == 6);
            drive();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    errors++; $display("FAIL ext_cycle%0d[%0d]: got %h expected %h", i, k, obs_vec(k), exp_vec(k));
                end
            end
            if (if_b.StallF) sb++;
            if (i <= 5) fd_b = fd_b | if_b.FlushD;
            tick();
        end
        checks++;
        if (sb != 5) begin
            errors++; $display("FAIL ext_stall_cycles: got %0d expected 5", sb);
        end
        checks++;
        if (fd_b !== 1'b0) begin
            errors++; $display("FAIL ext_flush_suppressed: got %b expected 0", fd_b);
        end
        checks++;
        if (if_b.FlushCnt !== 16'd0) begin
            errors++; $display("FAIL ext_flushcnt: got %0d expected 0", if_b.FlushCnt);
        end
        cur = '0;
        for (int i = 0; i < 5; i++) begin
            drive();
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++; $display("FAIL ext_drain%0d: got %h expected %h", i, obs_vec(0), exp_vec(0));
            end
            tick();
        end
    endtask

    task automatic test_branch_sat();
        cur = '0;
        cur.cntclear = 1'b1;
        drive();
        tick();
        cur = '0;
        drive();
        for (int k = 0; k < 3; k++)
            for (int w = 0; w < 3; w++) begin
                checks++;
                if (obs_cnt(k, w) != 0) begin
                    errors++; $display("FAIL clear[%0d][%0d]: got %0d expected 0", k, w, obs_cnt(k, w));
                end
            end
        cur.pcsrce = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive();
            if (i == 1) begin
                checks++;
                if ({if_a.FlushD, if_a.FlushE} !== 2'b11) begin
                    errors++; $display("FAIL branch_flush: got %b expected 11", {if_a.FlushD, if_a.FlushE});
                end
            end
            tick();
            checks++;
            if (if_a.FlushCnt !== 16'(i)) begin
                errors++; $display("FAIL branch_cnt%0d: got %0d expected %0d", i, if_a.FlushCnt, i);
            end
            checks++;
            if (if_c.FlushCnt !== 2'((i < 3) ? i : 3)) begin
                errors++; $display("FAIL branch_sat%0d: got %0d expected %0d", i, if_c.FlushCnt, (i < 3) ? i : 3);
            end
        end
        // clear wins over a simultaneous increment
        cur.cntclear = 1'b1;
        drive();
        tick();
        checks++;
        if (if_c.FlushCnt !== 2'd0 || if_a.FlushCnt !== 16'd0) begin
            errors++; $display("FAIL clear_priority: got %0d/%0d expected 0/0", if_a.FlushCnt, if_c.FlushCnt);
        end
        cur = '0;
        drive();
        tick();
    endtask

    task automatic test_reset_mid_op();
        cur = '0;
        cur.mcstarte = 1'b1;
        cur.pcsrce   = 1'b1;
        drive(); tick();
        drive(); tick();
        drive();
        checks++;
        if (if_a.MCBusy !== 1'b1 || if_b.MCBusy !== 1'b1) begin
            errors++; $display("FAIL midop_busy: got %b%b expected 11", if_a.MCBusy, if_b.MCBusy);
        end
        cur.mcstarte = 1'b0;
        cur.pcsrce   = 1'b0;
        drive();
        #1 RESETn = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs_vec(k) !== exp_vec(k) || obs_vec(k) !== 12'h000) begin
                errors++; $display("FAIL midop_reset[%0d]: got %h expected %h", k, obs_vec(k), exp_vec(k));
            end
            checks++;
            if (obs_cnt(k, 0) != 0 || obs_cnt(k, 1) != 0 || obs_cnt(k, 2) != 0) begin
                errors++; $display("FAIL midop_cnt[%0d]: got %0d/%0d/%0d expected 0/0/0",
                    k, obs_cnt(k, 0), obs_cnt(k, 1), obs_cnt(k, 2));
            end
        end
        tick();
        RESETn = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cur.ra1d = 4'($urandom_range(0, 3)); cur.ra2d = 4'($urandom_range(0, 3));
            cur.ra1e = 4'($urandom_range(0, 3)); cur.ra2e = 4'($urandom_range(0, 3));
            cur.wa3e = 4'($urandom_range(0, 3)); cur.wa3m = 4'($urandom_range(0, 3));
            cur.ra2m = 4'($urandom_range(0, 3)); cur.wa3w = 4'($urandom_range(0, 3));
            cur.memtorege = 1'($urandom_range(0, 1)); cur.regwritee = 1'($urandom_range(0, 1));
            cur.pcsrce    = ($urandom_range(0, 3) == 0);
            cur.mcstarte  = ($urandom_range(0, 3) != 0);
            cur.mcdone    = ($urandom_range(0, 3) == 0);
            cur.regwritem = 1'($urandom_range(0, 1)); cur.memwritem = 1'($urandom_range(0, 1));
            cur.regwritew = 1'($urandom_range(0, 1)); cur.memtoregw = 1'($urandom_range(0, 1));
            cur.cntclear  = ($urandom_range(0, 31) == 0);
            drive();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    errors++; $display("FAIL rand%0d_vec[%0d]: got %h expected %h", n, k, obs_vec(k), exp_vec(k));
                end
                for (int w = 0; w < 3; w++) begin
                    checks++;
                    if (obs_cnt(k, w) != exp_cnt(k, w)) begin
                        errors++; $display("FAIL rand%0d_cnt[%0d][%0d]: got %0d expected %0d",
                            n, k, w, obs_cnt(k, w), exp_cnt(k, w));
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RESETn = 1'b0;
        cur = '0;
        model_reset();
        @(negedge CLK);
        test_reset();
        test_forwarding();
        test_load_use();
        test_fixed_mul();
        test_ext_mode();
        test_branch_sat();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_mc.md
# hazard_mc

Parametrised pipeline hazard unit for the 5-stage ARM core. Resolves E-stage operand forwarding, LDR→STR memory forwarding, the one-cycle load-use stall and branch flushes. Adds a multi-cycle-operation (MUL/DIV) stall FSM that freezes F/D/E for a fixed or externally signalled latency. Keeps saturating stall/flush performance counters.

## Interface
- RA_W, 4, register-index width
- MC_LATENCY, 4, E-stage occupancy in cycles of a multi-cycle op in fixed mode (≥1)
- MC_EXT_DONE, 0, 0 = fixed-latency counter; 1 = completion signalled by MCDone
- CNT_W, 16, performance-counter width

- CLK  in  1  clock, rising edge
- RESETn  in  1  asynchronous, active-low reset
- RA1D, RA2D  in  RA_W  D-stage source registers
- RA1E, RA2E, WA3E  in  RA_W  E-stage sources / destination
- MemtoRegE, RegWriteE, PCSrcE  in  1  E-stage controls
- MCStartE  in  1  multi-cycle op occupies E (held high while it sits in E)
- MCDone  in  1  external completion pulse (used only when MC_EXT_DONE=1)
- WA3M, RA2M  in  RA_W; RegWriteM, MemWriteM  in  1  M-stage
- WA3W  in  RA_W; RegWriteW, MemtoRegW  in  1  W-stage
- CntClear  in  1  synchronous clear of all counters
- StallF, StallD, StallE  out  1  hold stage registers
- FlushD, FlushE, FlushM  out  1  bubble stage registers
- ForwardAE, ForwardBE  out  2  10 = from M, 01 = from W, 00 = register file
- ForwardM  out  1  W load result → M store data
- MCBusy  out  1  FSM in BUSY
- LdrStallCnt, McStallCnt, FlushCnt  out  CNT_W  performance counters

## Operation
- Forwarding (combinational): ForwardAE = 10 if RA1E==WA3M & RegWriteM; else 01 if RA1E==WA3W & RegWriteW; else 00. ForwardBE likewise with RA2E. M has priority over W.
- ForwardM = (RA2M==WA3W) & MemWriteM & MemtoRegW & RegWriteW.
- LdrStall = (RA1D==WA3E | RA2D==WA3E) & MemtoRegE & RegWriteE.
- MC FSM, states IDLE/BUSY, counter cnt (width clog2(MC_LATENCY)+1):
  - IDLE & MCStartE & (MC_EXT_DONE=1 or MC_LATENCY≥2): → BUSY; cnt ← MC_LATENCY−1.
  - BUSY: finish = (cnt==1) in fixed mode, MCDone in ext mode. Fixed mode: cnt decrements each cycle. On finish → IDLE.
  - MCDone is ignored in IDLE. MCStartE seen in BUSY does not restart the FSM.
- McStall = (IDLE & MCStartE & start-condition) | (BUSY & ~finish).
- Outputs:
  - StallF = StallD = LdrStall | McStall; StallE = McStall; FlushM = McStall.
  - FlushE = (LdrStall & ~McStall) | (PCSrcE & ~McStall).
  - FlushD = PCSrcE & ~McStall.
  - McStall overrides LdrStall and PCSrcE.
- Counters (each saturates at all-ones):
  - LdrStallCnt +1 per cycle with LdrStall & ~McStall.
  - McStallCnt +1 per McStall cycle.
  - FlushCnt +1 per cycle with FlushD.
  - CntClear zeroes all three and has priority over increment.

## Timing
- Reset (async, RESETn=0): state IDLE, cnt 0, counters 0, MCBusy 0. All other outputs follow the combinational equations with the FSM in IDLE.
- Forward*, Stall*, Flush* are combinational from inputs and state; counters and FSM update on CLK rise.
- Fixed mode, MCStartE first seen in cycle T: McStall high in T..T+MC_LATENCY−2, i.e. MC_LATENCY−1 stall cycles. MCBusy high T+1..T+MC_LATENCY−1. The op leaves E at the edge ending T+MC_LATENCY−1.
- MC_LATENCY=1: no stall; FSM stays IDLE.
- Ext mode: stall from T until the cycle MCDone=1 in BUSY (inclusive of T, exclusive of the done cycle).
- Back-to-back MC ops: the second op enters E in the cycle after finish, sees IDLE and restarts.
- RESETn asserted mid-BUSY: immediate IDLE and all stalls drop.

## Test plan
- Forwarding: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 → ForwardAE=10. Then RegWriteM=0 → 01. RA2M=5=WA3W, MemWriteM, MemtoRegW, RegWriteW → ForwardM=1.
- Load-use: RA2D=7, WA3E=7, MemtoRegE=RegWriteE=1 → StallF=StallD=FlushE=1, StallE=0; LdrStallCnt 0→1 after one edge.
- Fixed MUL, MC_LATENCY=4: MCStartE held 4 cycles → StallF/D/E and FlushM high exactly 3 cycles, MCBusy high cycles 2–4, McStallCnt=3.
- Ext mode: MCStartE held; MCDone pulses in the 6th cycle → 5 stall cycles. PCSrcE=1 during the stall → FlushD=0, FlushCnt unchanged.
- Branch: PCSrcE=1 in IDLE → FlushD=FlushE=1, FlushCnt+1. Set CNT_W=2 and apply 5 flush cycles → FlushCnt saturates at 3. CntClear → 0.
- Reset mid-op: RESETn low during BUSY → MCBusy=0, stalls 0, counters 0 without a clock edge.
